apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that turns a simple valid/ready command interface into a compliant APB SETUP/ACCESS transfer and returns the completion as a one-cycle response pulse. It sits directly upstream of `apb_slave` and drives its PADDR/PWRITE/PWDATA/PSELx/PENABLE inputs. It consumes the slave's PRDATA/PREADY/PSLVERR.

## Interface
- TIMEOUT_CYCLES, 16: max ACCESS wait cycles before abort (used only with timeout feature; range 1..65535)
- i_clk  in  1  APB clock; all logic rising-edge
- i_reset_n  in  1  reset: synchronous, active-low
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_addr  in  32  transfer address
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_wdata  in  32  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  read data (0 for writes and aborts)
- o_rsp_err  out  1  PSLVERR or timeout
- PADDR  out  32  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- All outputs are registered. Reset value of every output is 0, except o_cmd_ready, which is 1 (state IDLE).
- FSM states IDLE, SETUP, ACCESS. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid: latch addr/write/wdata into PADDR/PWRITE/PWDATA, set PSELx=1, PENABLE=0, o_cmd_ready=0 → SETUP.
- SETUP: set PENABLE=1 → ACCESS. This transition is unconditional; SETUP lasts exactly one cycle.
- ACCESS, PREADY=0: hold all APB outputs stable (wait state).
- ACCESS, PREADY=1:
  - o_rsp_valid=1.
  - o_rsp_err=PSLVERR.
  - o_rsp_rdata=PWRITE ? 0 : PRDATA.
  - PSELx=0, PENABLE=0, o_cmd_ready=1 → IDLE.
- o_rsp_valid is a pulse with no backpressure. o_rsp_rdata and o_rsp_err hold until the next response.
- PADDR, PWRITE and PWDATA keep their last value after a transfer. PSELx=0 qualifies them.
- At most one outstanding transfer; there is no back-to-back SETUP. A command presented in the response cycle is accepted that cycle (o_cmd_ready=1).
- Reset mid-transfer: next edge returns to IDLE, PSELx/PENABLE=0, no response is issued for the aborted transfer.

## Timing
- Command accepted at edge N. SETUP phase (PSELx=1, PENABLE=0) is visible during cycle N..N+1. ACCESS (PENABLE=1) starts after edge N+1.
- PREADY is sampled on every ACCESS edge. If PREADY is high at edge N+2+W (W wait cycles), o_rsp_valid is high in the following cycle.
- Minimum command-to-response latency is 3 cycles. Minimum transfer period is 3 cycles.
- PSELx/PENABLE fall on the same edge that raises o_rsp_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=0, PSELx/PENABLE=0 → IDLE.
  - PREADY=1 on the same edge as the limit wins: it is a normal completion.
- Undefined: no counter. ACCESS waits indefinitely and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package `apb_pkg`:
  - state localparams IDLE=0, SETUP=1, ACCESS=2 (the same encoding `apb_slave` uses)
  - APB_ADDR_W=32, APB_DATA_W=32
- One sub-module: `apb_wait_timer` (clear, enable, limit → expired). Instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write: cmd addr=0x3, wdata=0xDEADBEEF, slave PREADY=1 in first ACCESS → PSELx 1 for 2 cycles, PENABLE 1 for 1 cycle, PWDATA=0xDEADBEEF, o_rsp_valid pulse 3 cycles after accept, err=0, rdata=0.
- Read: after the write, cmd read addr=0x3, PRDATA=0xDEADBEEF with 2 wait states → response 5 cycles after accept, rdata=0xDEADBEEF, APB outputs stable during waits.
- Error: read addr=0x20, PSLVERR=1 with PREADY → o_rsp_err=1. Next command with i_cmd_valid held high is accepted in the response cycle.
- Reset mid-ACCESS: hold PREADY=0, drop i_reset_n one cycle → PSELx=PENABLE=0, o_cmd_ready=1, no o_rsp_valid.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY stuck 0 → response err=1, rdata=0 after 4 ACCESS wait cycles. Without the macro: no response after 100 cycles.
- Timeout boundary: PREADY=1 exactly at count 4 with PRDATA=0x55 → err=PSLVERR (0), rdata=0x55.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding (matches apb_slave) and bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_SETUP  = SETUP,
    S_ACCESS = ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for an APB ACCESS phase. Clear resets the count, enable
// advances it, expired is high while the count equals the limit.
module apb_wait_timer (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;

  // Count wait cycles; clear has priority over enable.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS
// transfer out, one-cycle response pulse back.
// Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_cmd_addr,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PSELx,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES);

  apb_state_e state, state_n;

  logic [APB_ADDR_W-1:0] paddr_n;
  logic [APB_DATA_W-1:0] pwdata_n;
  logic [APB_DATA_W-1:0] rsp_rdata_n;
  logic                  pwrite_n;
  logic                  psel_n;
  logic                  penable_n;
  logic                  cmd_ready_n;
  logic                  rsp_valid_n;
  logic                  rsp_err_n;
  logic                  timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic wait_expired;

  // Count clears while in SETUP so it starts at zero on the first ACCESS edge;
  // it stops advancing once the limit is reached.
  apb_wait_timer u_wait_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (state == S_SETUP),
    .enable    ((state == S_ACCESS) && !PREADY && !wait_expired),
    .limit     (WAIT_LIMIT),
    .expired   (wait_expired)
  );

  assign timeout_hit = wait_expired;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^WAIT_LIMIT;
  assign timeout_hit        = 1'b0;
`endif

  // State and registered outputs; every output resets to 0 except cmd_ready.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      state       <= state_n;
      o_cmd_ready <= cmd_ready_n;
      o_rsp_valid <= rsp_valid_n;
      o_rsp_rdata <= rsp_rdata_n;
      o_rsp_err   <= rsp_err_n;
      PADDR       <= paddr_n;
      PWRITE      <= pwrite_n;
      PWDATA      <= pwdata_n;
      PSELx       <= psel_n;
      PENABLE     <= penable_n;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_n     = state;
    cmd_ready_n = o_cmd_ready;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = o_rsp_rdata;
    rsp_err_n   = o_rsp_err;
    paddr_n     = PADDR;
    pwrite_n    = PWRITE;
    pwdata_n    = PWDATA;
    psel_n      = PSELx;
    penable_n   = PENABLE;

    case (state)
      S_IDLE: begin
        cmd_ready_n = 1'b1;
        if (i_cmd_valid) begin
          paddr_n     = i_cmd_addr;
          pwrite_n    = i_cmd_write;
          pwdata_n    = i_cmd_wdata;
          psel_n      = 1'b1;
          penable_n   = 1'b0;
          cmd_ready_n = 1'b0;
          state_n     = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_n = 1'b1;
        state_n   = S_ACCESS;
      end
      S_ACCESS: begin
        // A ready on the limit edge completes normally; timeout only without it.
        if (PREADY) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = PSLVERR;
          rsp_rdata_n = PWRITE ? '0 : PRDATA;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = S_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: begin
        psel_n      = 1'b0;
        penable_n   = 1'b0;
        cmd_ready_n = 1'b1;
        state_n     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, slave error with a
// command accepted in the response cycle, reset mid-ACCESS, and the ACCESS
// timeout (or its absence) depending on APB_MASTER_TIMEOUT_EN.
module tb_apb_master;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [31:0] i_cmd_addr;
  logic        i_cmd_write;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_write (i_cmd_write),
    .i_cmd_wdata (i_cmd_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Packs {cmd_ready, psel, penable, rsp_valid, rsp_err} for compact checks.
  function automatic logic [31:0] ctl();
    return {27'd0, o_cmd_ready, PSELx, PENABLE, o_rsp_valid, o_rsp_err};
  endfunction

  initial begin
    i_reset_n   = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_write = 1'b0;
    i_cmd_wdata = '0;
    PRDATA      = '0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_ctl",   ctl(), 32'b10000);
    check("reset_paddr", PADDR, 32'h0);
    check("reset_rdata", o_rsp_rdata, 32'h0);
    i_reset_n = 1'b1;
    tick();
    check("idle_ctl", ctl(), 32'b10000);

    // Write, zero wait states
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h3; i_cmd_write = 1'b1; i_cmd_wdata = 32'hDEADBEEF;
    PREADY = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check("wr_setup_ctl", ctl(), 32'b01000);
    check("wr_paddr",     PADDR, 32'h3);
    check("wr_pwrite",    {31'd0, PWRITE}, 32'h1);
    check("wr_pwdata",    PWDATA, 32'hDEADBEEF);
    tick();
    check("wr_access_ctl", ctl(), 32'b01100);
    tick();
    check("wr_rsp_ctl",   ctl(), 32'b10010);
    check("wr_rsp_rdata", o_rsp_rdata, 32'h0);
    tick();
    check("wr_after_ctl",    ctl(), 32'b10000);
    check("wr_pwdata_holds", PWDATA, 32'hDEADBEEF);

    // Read with two wait states
    PREADY = 1'b0; PRDATA = 32'hDEADBEEF;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h3; i_cmd_write = 1'b0; i_cmd_wdata = 32'h0;
    tick();
    i_cmd_valid = 1'b0;
    check("rd_setup_ctl", ctl(), 32'b01000);
    check("rd_pwrite",    {31'd0, PWRITE}, 32'h0);
    tick();
    check("rd_access_ctl", ctl(), 32'b01100);
    tick();
    check("rd_wait1_ctl",   ctl(), 32'b01100);
    check("rd_wait1_paddr", PADDR, 32'h3);
    tick();
    check("rd_wait2_ctl",   ctl(), 32'b01100);
    check("rd_wait2_paddr", PADDR, 32'h3);
    PREADY = 1'b1;
    tick();
    check("rd_rsp_ctl",   ctl(), 32'b10010);
    check("rd_rsp_rdata", o_rsp_rdata, 32'hDEADBEEF);

    // Slave error, then a command accepted in the response cycle
    PSLVERR = 1'b1; PRDATA = 32'h1234;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h20; i_cmd_write = 1'b0;
    tick();
    check("err_setup_ctl", ctl(), 32'b01000);
    check("err_paddr",     PADDR, 32'h20);
    tick();
    check("err_access_ctl", ctl(), 32'b01100);
    tick();
    check("err_rsp_ctl",   ctl(), 32'b10011);
    check("err_rsp_rdata", o_rsp_rdata, 32'h1234);
    PSLVERR = 1'b0;
    tick();
    i_cmd_valid = 1'b0;
    check("b2b_setup_ctl", ctl(), 32'b01001);
    tick();
    check("b2b_access_ctl", ctl(), 32'b01101);
    tick();
    check("b2b_rsp_ctl", ctl(), 32'b10010);
    tick();

    // Reset in the middle of ACCESS
    PREADY = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h8; i_cmd_write = 1'b1; i_cmd_wdata = 32'h77;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    tick();
    check("rst_pre_ctl", ctl(), 32'b01100);
    i_reset_n = 1'b0;
    tick();
    check("rst_mid_ctl", ctl(), 32'b10000);
    i_reset_n = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_rsp", ctl(), 32'b10000);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Ready arriving exactly at the limit is a normal completion
    PREADY = 1'b0; PRDATA = 32'h55; PSLVERR = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h30; i_cmd_write = 1'b0;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bnd_wait_ctl", ctl(), 32'b01100);
    end
    PREADY = 1'b1;
    tick();
    check("bnd_rsp_ctl",   ctl(), 32'b10010);
    check("bnd_rsp_rdata", o_rsp_rdata, 32'h55);

    // PREADY stuck low: abort with error after four wait cycles
    PREADY = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h34; i_cmd_write = 1'b0;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait_ctl", ctl(), 32'b01100);
    end
    tick();
    check("to_rsp_ctl",   ctl(), 32'b10011);
    check("to_rsp_rdata", o_rsp_rdata, 32'h0);
    tick();
    check("to_after_ctl", ctl(), 32'b10001);
`else
    // PREADY stuck low: the transfer waits indefinitely
    PREADY = 1'b0; PRDATA = 32'h55;
    i_cmd_valid = 1'b1; i_cmd_addr = 32'h34; i_cmd_write = 1'b0;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      check("stuck_no_rsp", {31'd0, o_rsp_valid}, 32'h0);
    end
    check("stuck_ctl", ctl(), 32'b01100);
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    check("stuck_reset_ctl", ctl(), 32'b10000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
